// File: rtl/watch_set_ctrl_if.sv
// Front-panel key inputs, 1 Hz tick and the mode/set outputs of the watch set controller.
// The master side drives keys and ticks; the slave side is the controller.
interface watch_set_ctrl_if;
  logic one_second;
  logic key_mode;
  logic key_adjust;
  logic state;
  logic minute_set;
  logic hour_set;
  logic blink_minute;
  logic blink_hour;

  modport master (
    output one_second, key_mode, key_adjust,
    input  state, minute_set, hour_set, blink_minute, blink_hour
  );

  modport slave (
    input  one_second, key_mode, key_adjust,
    output state, minute_set, hour_set, blink_minute, blink_hour
  );
endinterface

// File: rtl/watch_set_ctrl.sv
// Watch mode/set sequencer: MODE steps Timer -> Set hour -> Set minute, ADJUST issues
// increment pulses with press-and-hold auto-repeat, idle timeout and field blink.
//
// state    | meaning
// ---------+---------------------------------------------
// TIMER    | time runs, no adjust pulses, no blinking
// SET_HOUR | ADJUST pulses hour_set, hour digits blink
// SET_MIN  | ADJUST pulses minute_set, minute digits blink
module watch_set_ctrl #(
  parameter logic [23:0] REPEAT_DLY  = 24'd12_000_000,
  parameter logic [23:0] REPEAT_PER  = 24'd3_000_000,
  parameter logic [5:0]  TIMEOUT_SEC = 6'd30
) (
  input logic             clock,
  input logic             reset,
  watch_set_ctrl_if.slave bus
);

  localparam logic [1:0] TIMER    = 2'd0;
  localparam logic [1:0] SET_HOUR = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;

  logic [1:0]  fsm;
  logic [1:0]  fsm_next;
  logic        key_mode_d;
  logic        key_adjust_d;
  logic        mode_rise;
  logic        adj_rise;
  logic        in_set;
  logic        fire;
  logic        activity;
  logic        timeout;
  logic [23:0] rep_cnt;
  logic        rep_active;
  logic [24:0] rep_inc;
  logic [23:0] rep_thr;
  logic        rep_hit;
  logic [5:0]  idle_cnt;
  logic [6:0]  idle_inc;
  logic        phase;
  logic        state_q;
  logic        minute_q;
  logic        hour_q;

  assign mode_rise = bus.key_mode & ~key_mode_d;
  assign adj_rise  = bus.key_adjust & ~key_adjust_d;
  assign in_set    = (fsm == SET_HOUR) | (fsm == SET_MIN);

  // first repeat waits REPEAT_DLY, later ones REPEAT_PER; >= keeps a stale count from stalling
  assign rep_inc  = {1'b0, rep_cnt} + 25'd1;
  assign rep_thr  = rep_active ? REPEAT_PER : REPEAT_DLY;
  assign rep_hit  = bus.key_adjust & (rep_inc >= {1'b0, rep_thr});
  assign fire     = in_set & ~mode_rise & (adj_rise | rep_hit);
  assign activity = mode_rise | adj_rise | fire;

  assign idle_inc = {1'b0, idle_cnt} + 7'd1;
  assign timeout  = in_set & bus.one_second & ~activity & (idle_inc >= {1'b0, TIMEOUT_SEC});

  always_comb begin
    fsm_next = fsm;
    if (mode_rise) begin
      case (fsm)
        TIMER:    fsm_next = SET_HOUR;
        SET_HOUR: fsm_next = SET_MIN;
        default:  fsm_next = TIMER;
      endcase
    end else if (timeout || !in_set) begin
      fsm_next = TIMER;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm          <= TIMER;
      key_mode_d   <= 1'b1;
      key_adjust_d <= 1'b1;
      rep_cnt      <= '0;
      rep_active   <= 1'b0;
      idle_cnt     <= '0;
      phase        <= 1'b0;
      state_q      <= 1'b1;
      minute_q     <= 1'b0;
      hour_q       <= 1'b0;
    end else begin
      fsm          <= fsm_next;
      key_mode_d   <= bus.key_mode;
      key_adjust_d <= bus.key_adjust;
      state_q      <= (fsm_next == TIMER);
      hour_q       <= fire & (fsm == SET_HOUR);
      minute_q     <= fire & (fsm == SET_MIN);

      if (!in_set || mode_rise || !bus.key_adjust) begin
        rep_cnt    <= '0;
        rep_active <= 1'b0;
      end else if (rep_hit) begin
        rep_cnt    <= '0;
        rep_active <= 1'b1;
      end else if (rep_cnt != '1) begin
        rep_cnt <= rep_inc[23:0];
      end

      if ((fsm_next == TIMER) || activity) begin
        idle_cnt <= '0;
      end else if (bus.one_second && (idle_cnt < TIMEOUT_SEC)) begin
        idle_cnt <= idle_inc[5:0];
      end

      // every entry into a Set state starts with the digits visible
      if ((fsm_next == TIMER) || mode_rise) begin
        phase <= 1'b0;
      end else if (bus.one_second) begin
        phase <= ~phase;
      end
    end
  end

  assign bus.state        = state_q;
  assign bus.minute_set   = minute_q;
  assign bus.hour_set     = hour_q;
  assign bus.blink_hour   = phase & (fsm == SET_HOUR);
  assign bus.blink_minute = phase & (fsm == SET_MIN);

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Scoreboard bench for watch_set_ctrl: a behavioural model predicts the outputs of every cycle,
// a monitor compares them one cycle later; directed scenarios are followed by random key traffic.
module tb_watch_set_ctrl;

  localparam int DLY  = 10;
  localparam int PER  = 4;
  localparam int TSEC = 3;

  logic clock = 1'b0;
  logic reset;

  watch_set_ctrl_if bus ();

  watch_set_ctrl #(
    .REPEAT_DLY (24'd10),
    .REPEAT_PER (24'd4),
    .TIMEOUT_SEC(6'd3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // expected vector: {state, minute_set, hour_set, blink_minute, blink_hour}
  logic [4:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int cycle_no = 0;
  int min_pulses = 0;

  // model: mode 0=timer 1=set hour 2=set minute; hold = samples ADJUST has been held in this Set state
  int m_mode, m_hold, m_idle;
  bit m_pk, m_pa, m_phase;

  task automatic model_step(input bit r, input bit os, input bit km, input bit ka);
    bit mrise, arise, pulse, setm;
    int nmode, hn;
    logic [4:0] e;
    if (r) begin
      m_mode = 0; m_pk = 1; m_pa = 1; m_hold = 0; m_idle = 0; m_phase = 0;
      exp_q.push_back(5'b10000);
      return;
    end
    mrise = km && !m_pk;
    arise = ka && !m_pa;
    setm  = (m_mode != 0);
    hn    = (setm && !mrise && ka) ? m_hold + 1 : 0;
    pulse = setm && !mrise && (arise || (hn >= DLY && ((hn - DLY) % PER) == 0));
    nmode = m_mode;
    if (mrise) nmode = (m_mode + 1) % 3;
    else if (setm && os && !arise && !pulse && (m_idle + 1 >= TSEC)) nmode = 0;
    if (nmode == 0 || mrise || arise || pulse) m_idle = 0;
    else if (os && m_idle < TSEC) m_idle = m_idle + 1;
    if (nmode == 0 || mrise) m_phase = 0;
    else if (os) m_phase = !m_phase;
    e = {nmode == 0, pulse && m_mode == 2, pulse && m_mode == 1,
         m_phase && nmode == 2, m_phase && nmode == 1};
    m_mode = nmode; m_pk = km; m_pa = ka; m_hold = hn;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit os, input bit km, input bit ka);
    reset          = r;
    bus.one_second = os;
    bus.key_mode   = km;
    bus.key_adjust = ka;
    model_step(r, os, km, ka);
    @(negedge clock);
  endtask

  task automatic press_mode();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 4 && m_mode != target; i++) press_mode();
  endtask

  task automatic check_val(input string name, input logic got, input logic exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
  endtask

  always begin
    logic [4:0] exp, got;
    @(posedge clock);
    #1;
    cycle_no++;
    if (bus.minute_set === 1'b1) min_pulses++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.state, bus.minute_set, bus.hour_set, bus.blink_minute, bus.blink_hour};
      checks++;
      if (got === exp) passed++;
      else $display("FAIL outputs cycle=%0d got(st,ms,hs,bm,bh)=%b exp=%b", cycle_no, got, exp);
    end
  end

  initial begin
    bit km, ka;
    // reset with MODE held through it: no edge afterwards
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    repeat (5) cyc(0, 0, 1, 0);
    check_val("no_edge_after_reset", bus.state, 1'b1);
    cyc(0, 0, 0, 0);

    // three presses walk the full cycle
    repeat (3) begin
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    check_val("back_to_timer", bus.state, 1'b1);

    // single adjust taps in each Set state
    goto_mode(1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    goto_mode(2);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // 30-cycle hold in SET_MIN: pulses at 1,10,14,18,22,26,30
    min_pulses = 0;
    repeat (30) cyc(0, 0, 0, 1);
    repeat (8) cyc(0, 0, 0, 0);
    check_val("hold_pulse_count_is_7", min_pulses == 7, 1'b1);

    // idle timeout from SET_HOUR after the third tick
    goto_mode(1);
    repeat (3) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    check_val("timeout_state", bus.state, 1'b1);
    check_val("timeout_blink_hour", bus.blink_hour, 1'b0);

    // MODE on the same cycle as the third tick wins
    goto_mode(1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    check_val("mode_beats_timeout", bus.state, 1'b0);

    // MODE and ADJUST together in SET_HOUR: advance, no pulse
    goto_mode(1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // held ADJUST carried across a mode change
    goto_mode(1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    repeat (14) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // reset mid-hold aborts repeat
    repeat (5) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    repeat (12) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // random key traffic
    km = 0;
    ka = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) km = ~km;
      if ($urandom_range(0, 7) == 0) ka = ~ka;
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0, km, ka);
    end

    repeat (2) @(posedge clock);
    #3;
    check_val("scoreboard_drained", exp_q.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
